// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter
//
// Round-robin arbiter and sequencer sharing one single-byte I2C register-write
// engine between NUM_REQ requesters. The winner's device address, register
// address and data byte are latched and held while the engine runs. Each
// transaction ends on engine done or on timeout. A forced idle gap then lets
// the engine return to its reset state before the next grant.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester level request
//   req_dev_addr    7-bit device address per requester, slice i = [7i+6:7i]
//   req_reg_addr    8-bit register address per requester
//   req_data        8-bit data byte per requester
//   grant           one-hot, high while the owner's transaction is running
//   ack_done        one-cycle pulse on completion
//   ack_err         one-cycle pulse on timeout
//   busy            high whenever the sequencer is not idle
//   send_enable     engine enable
//   dev_addr        engine device address
//   dev_inner_addr  engine register address
//   send_data       engine data byte
//   send_done       engine done level, only observed while running

module i2c_write_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096,
   parameter int unsigned GAP_CYCLES     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [7*NUM_REQ-1:0] req_dev_addr,
   input  logic [8*NUM_REQ-1:0] req_reg_addr,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   ack_done,
   output logic [NUM_REQ-1:0]   ack_err,
   output logic                 busy,
   output logic                 send_enable,
   output logic [6:0]           dev_addr,
   output logic [7:0]           dev_inner_addr,
   output logic [7:0]           send_data,
   input  logic                 send_done
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned GapW = $clog2(GAP_CYCLES);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRun  = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IdxW-1:0]    last_q, last_d;
   logic [TmoW-1:0]    tmo_q, tmo_d;
   logic [GapW-1:0]    gap_q, gap_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ack_done_q, ack_done_d;
   logic [NUM_REQ-1:0] ack_err_q, ack_err_d;
   logic               busy_q, busy_d;
   logic               send_enable_q, send_enable_d;
   logic [6:0]         dev_addr_q, dev_addr_d;
   logic [7:0]         inner_q, inner_d;
   logic [7:0]         data_q, data_d;

   // Per-requester views of the packed field buses.
   logic [6:0] dev_arr  [NUM_REQ];
   logic [7:0] reg_arr  [NUM_REQ];
   logic [7:0] data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign dev_arr[g]  = req_dev_addr[7*g +: 7];
      assign reg_arr[g]  = req_reg_addr[8*g +: 8];
      assign data_arr[g] = req_data[8*g +: 8];
   end

   // Round-robin search starting just after the last owner; the last owner is
   // checked last so it cannot win twice while others are waiting.
   logic [IdxW-1:0] win, cand;
   logic            found;

   always_comb begin
      win   = last_q;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
         cand = IdxW'((int'(last_q) + k) % int'(NUM_REQ));
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   // last_q holds the current owner while running.
   logic [NUM_REQ-1:0] owner_onehot;
   assign owner_onehot = NUM_REQ'(1) << last_q;

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      tmo_d         = tmo_q;
      gap_d         = gap_q;
      grant_d       = grant_q;
      ack_done_d    = '0;
      ack_err_d     = '0;
      send_enable_d = send_enable_q;
      dev_addr_d    = dev_addr_q;
      inner_d       = inner_q;
      data_d        = data_q;

      case (state_q)
         StIdle: begin
            if (found) begin
               dev_addr_d    = dev_arr[win];
               inner_d       = reg_arr[win];
               data_d        = data_arr[win];
               grant_d       = NUM_REQ'(1) << win;
               send_enable_d = 1'b1;
               last_d        = win;
               tmo_d         = '0;
               state_d       = StRun;
            end
         end
         StRun: begin
            // Done takes priority over a coincident timeout.
            if (send_done) begin
               ack_done_d    = owner_onehot;
               grant_d       = '0;
               send_enable_d = 1'b0;
               gap_d         = '0;
               state_d       = StGap;
            end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
               ack_err_d     = owner_onehot;
               grant_d       = '0;
               send_enable_d = 1'b0;
               gap_d         = '0;
               state_d       = StGap;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         StGap: begin
            grant_d       = '0;
            send_enable_d = 1'b0;
            if (gap_q == GapW'(GAP_CYCLES - 1)) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: begin
            grant_d       = '0;
            send_enable_d = 1'b0;
            state_d       = StIdle;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         last_q        <= IdxW'(NUM_REQ - 1);
         tmo_q         <= '0;
         gap_q         <= '0;
         grant_q       <= '0;
         ack_done_q    <= '0;
         ack_err_q     <= '0;
         busy_q        <= 1'b0;
         send_enable_q <= 1'b0;
         dev_addr_q    <= '0;
         inner_q       <= '0;
         data_q        <= '0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         tmo_q         <= tmo_d;
         gap_q         <= gap_d;
         grant_q       <= grant_d;
         ack_done_q    <= ack_done_d;
         ack_err_q     <= ack_err_d;
         busy_q        <= busy_d;
         send_enable_q <= send_enable_d;
         dev_addr_q    <= dev_addr_d;
         inner_q       <= inner_d;
         data_q        <= data_d;
      end
   end

   assign grant          = grant_q;
   assign ack_done       = ack_done_q;
   assign ack_err        = ack_err_q;
   assign busy           = busy_q;
   assign send_enable    = send_enable_q;
   assign dev_addr       = dev_addr_q;
   assign dev_inner_addr = inner_q;
   assign send_data      = data_q;

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Directed bench for i2c_write_arbiter. Instance ua uses the default timeout;
// instance ub uses a 16-cycle timeout for the timeout and coincidence cases.
// Both share clock, reset, requests and field buses.

module tb_i2c_write_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [27:0] req_dev_addr;
   logic [31:0] req_reg_addr;
   logic [31:0] req_data;
   logic        send_done_a, send_done_b;

   logic [3:0] grant_a, ack_done_a, ack_err_a;
   logic       busy_a, se_a;
   logic [6:0] dev_a;
   logic [7:0] inner_a, data_a;

   logic [3:0] grant_b, ack_done_b, ack_err_b;
   logic       busy_b, se_b;
   logic [6:0] dev_b;
   logic [7:0] inner_b, data_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   i2c_write_arbiter #(
      .NUM_REQ(4), .TIMEOUT_CYCLES(4096), .GAP_CYCLES(8)
   ) ua (
      .clk(clk), .rst(rst), .req(req),
      .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
      .grant(grant_a), .ack_done(ack_done_a), .ack_err(ack_err_a), .busy(busy_a),
      .send_enable(se_a), .dev_addr(dev_a), .dev_inner_addr(inner_a), .send_data(data_a),
      .send_done(send_done_a)
   );

   i2c_write_arbiter #(
      .NUM_REQ(4), .TIMEOUT_CYCLES(16), .GAP_CYCLES(8)
   ) ub (
      .clk(clk), .rst(rst), .req(req),
      .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_data(req_data),
      .grant(grant_b), .ack_done(ack_done_b), .ack_err(ack_err_b), .busy(busy_b),
      .send_enable(se_b), .dev_addr(dev_b), .dev_inner_addr(inner_b), .send_data(data_b),
      .send_done(send_done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_fields(input int i, input logic [6:0] d, input logic [7:0] r,
                             input logic [7:0] v);
      req_dev_addr[7*i +: 7] = d;
      req_reg_addr[8*i +: 8] = r;
      req_data[8*i +: 8]     = v;
   endtask

   initial begin
      int n;
      int bad;
      logic [3:0] exp_g;

      rst = 1'b1;
      req = 4'b0000;
      send_done_a = 1'b0;
      send_done_b = 1'b0;
      req_dev_addr = '0;
      req_reg_addr = '0;
      req_data = '0;
      set_fields(0, 7'h11, 8'h22, 8'h33);
      set_fields(1, 7'h50, 8'h1A, 8'hC3);
      set_fields(2, 7'h44, 8'h55, 8'h66);
      set_fields(3, 7'h77, 8'h88, 8'h99);
      tick();
      tick();

      // Reset state
      chk("rst_grant", 32'(grant_a), 32'h0);
      chk("rst_send_enable", 32'(se_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_dev_addr", 32'(dev_a), 32'h0);
      chk("rst_ack_done", 32'(ack_done_a), 32'h0);
      chk("rst_ack_err", 32'(ack_err_a), 32'h0);
      chk("rst_send_data", 32'(data_a), 32'h0);

      // Single request on index 1
      rst = 1'b0;
      req = 4'b0010;
      tick();
      chk("single_grant", 32'(grant_a), 32'h2);
      chk("single_send_enable", 32'(se_a), 32'h1);
      chk("single_dev_addr", 32'(dev_a), 32'h50);
      chk("single_inner_addr", 32'(inner_a), 32'h1A);
      chk("single_send_data", 32'(data_a), 32'hC3);
      chk("single_busy", 32'(busy_a), 32'h1);
      bad = 0;
      for (int i = 1; i < 100; i++) begin
         tick();
         if (!se_a || ack_done_a != 4'b0 || ack_err_a != 4'b0) bad++;
      end
      chk("single_hold_run", 32'(bad), 32'h0);
      send_done_a = 1'b1;
      tick();
      chk("single_ack_done", 32'(ack_done_a), 32'h2);
      chk("single_ack_err", 32'(ack_err_a), 32'h0);
      chk("single_se_low", 32'(se_a), 32'h0);
      chk("single_grant_low", 32'(grant_a), 32'h0);
      send_done_a = 1'b0;
      req = 4'b0000;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (se_a || ack_done_a != 4'b0) bad++;
      end
      chk("single_gap_quiet", 32'(bad), 32'h0);
      chk("single_idle_busy", 32'(busy_a), 32'h0);

      // Fairness: all four requesting for eight transactions
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         n = 0;
         while (!se_a && n < 40) begin
            n++;
            tick();
         end
         if (t > 0) chk("fair_low_cycles", 32'(n), 32'd9);
         exp_g = 4'b0001 << (t % 4);
         chk("fair_grant", 32'(grant_a), 32'(exp_g));
         tick();
         tick();
         send_done_a = 1'b1;
         tick();
         chk("fair_ack_done", 32'(ack_done_a), 32'(exp_g));
         send_done_a = 1'b0;
      end
      req = 4'b0000;

      // Timeout on ub, send_done never rises
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      chk("tmo_grant", 32'(grant_b), 32'h4);
      n = 0;
      bad = 0;
      while (se_b && n < 100) begin
         n++;
         if (ack_done_b != 4'b0) bad++;
         tick();
      end
      chk("tmo_enable_cycles", 32'(n), 32'd16);
      chk("tmo_ack_err", 32'(ack_err_b), 32'h4);
      chk("tmo_no_ack_done", 32'(ack_done_b) + 32'(bad), 32'h0);
      req = 4'b0000;
      tick();
      chk("tmo_err_one_pulse", 32'(ack_err_b), 32'h0);

      // Done coinciding with the last timeout cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1000;
      tick();
      chk("coin_grant", 32'(grant_b), 32'h8);
      repeat (15) tick();
      chk("coin_still_run", 32'(se_b), 32'h1);
      send_done_b = 1'b1;
      tick();
      chk("coin_ack_done", 32'(ack_done_b), 32'h8);
      chk("coin_no_ack_err", 32'(ack_err_b), 32'h0);
      send_done_b = 1'b0;
      req = 4'b0000;

      // Reset in the middle of a transaction on index 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_fields(0, 7'h2B, 8'h3C, 8'hA5);
      req = 4'b0001;
      tick();
      chk("mid_grant", 32'(grant_a), 32'h1);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      chk("mid_rst_grant", 32'(grant_a), 32'h0);
      chk("mid_rst_se", 32'(se_a), 32'h0);
      chk("mid_rst_busy", 32'(busy_a), 32'h0);
      chk("mid_rst_acks", 32'(ack_done_a | ack_err_a), 32'h0);
      chk("mid_rst_fields", {9'h0, dev_a, inner_a, data_a}, 32'h0);
      // last_grant returns to 3, so index 0 beats index 1
      rst = 1'b0;
      req = 4'b0011;
      tick();
      chk("post_rst_grant", 32'(grant_a), 32'h1);
      chk("post_rst_dev_addr", 32'(dev_a), 32'h2B);
      chk("post_rst_no_ack", 32'(ack_done_a | ack_err_a), 32'h0);

      // Field and request changes during the run are ignored
      req_data[7:0] = 8'h5A;
      req = 4'b0010;
      repeat (5) tick();
      chk("stab_send_data", 32'(data_a), 32'hA5);
      chk("stab_grant", 32'(grant_a), 32'h1);
      send_done_a = 1'b1;
      tick();
      chk("stab_ack_done", 32'(ack_done_a), 32'h1);
      send_done_a = 1'b0;
      n = 0;
      while (!se_a && n < 40) begin
         n++;
         tick();
      end
      chk("stab_next_low_cycles", 32'(n), 32'd9);
      chk("stab_next_grant", 32'(grant_a), 32'h2);
      req = 4'b0000;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
